// File: rtl/dmem_arb_pkg.sv
// Shared encodings and the address range helper for the data memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_IO  = 1'b1
  } owner_t;

  localparam int CMP_WIDTH = 64;

  // True when any bit above the memory index width is set.
  function automatic logic addr_out_of_range(input logic [CMP_WIDTH-1:0] addr,
                                             input int addr_width);
    return (addr >> addr_width) != '0;
  endfunction

endpackage

// File: rtl/dmem_arb_select.sv
// Combinational winner pick for the data memory arbiter.
// DMEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise the CPU always wins ties.
module dmem_arb_select
  import dmem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic io_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    grant_valid = cpu_req | io_req;
    grant_owner = OWN_CPU;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (cpu_req && io_req) begin
      grant_owner = (last_owner == OWN_CPU) ? OWN_IO : OWN_CPU;
    end else if (io_req) begin
      grant_owner = OWN_IO;
    end
`else
    if (!cpu_req && io_req) begin
      grant_owner = OWN_IO;
    end
`endif
  end

`ifndef DMEM_ARB_ROUND_ROBIN_EN
  // Fixed priority ignores the fairness pointer.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: IDLE -> ISSUE -> RESP per transaction.
// Tie-breaking policy is chosen in dmem_arb_select by DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_write,
  input  logic [DATA_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  io_req,
  input  logic                  io_write,
  input  logic [DATA_WIDTH-1:0] io_address,
  input  logic [DATA_WIDTH-1:0] io_wdata,
  output logic                  io_ack,
  output logic [DATA_WIDTH-1:0] io_rdata,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_input_data,
  input  logic [DATA_WIDTH-1:0] mem_output_data,
  output logic                  addr_error,
  output logic                  busy
);

  state_t                state_q, state_d;
  owner_t                owner_q, last_owner_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic                  grant_valid, grant_owner;
  logic                  sel_write;
  logic [DATA_WIDTH-1:0] sel_address, sel_wdata;
  logic                  addr_oor;

  dmem_arb_select u_select (
    .cpu_req     (cpu_req),
    .io_req      (io_req),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    sel_write   = cpu_write;
    sel_address = cpu_address;
    sel_wdata   = cpu_wdata;
    if (grant_owner == OWN_IO) begin
      sel_write   = io_write;
      sel_address = io_address;
      sel_wdata   = io_wdata;
    end
  end

  assign addr_oor = addr_out_of_range(CMP_WIDTH'(addr_q), ADDR_WIDTH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_IO;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_valid) begin
        owner_q      <= owner_t'(grant_owner);
        last_owner_q <= owner_t'(grant_owner);
        write_q      <= sel_write;
        addr_q       <= sel_address;
        wdata_q      <= sel_wdata;
      end
      // Stores and out-of-range accesses return zero rather than whatever the memory drives.
      if (state_q == ISSUE) begin
        rdata_q <= (write_q || addr_oor) ? '0 : mem_output_data;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_input_data   = '0;
    cpu_ack          = 1'b0;
    io_ack           = 1'b0;
    cpu_rdata        = '0;
    io_rdata         = '0;
    addr_error       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) state_d = ISSUE;
      end
      ISSUE: begin
        mem_address      = addr_q;
        mem_input_data   = wdata_q;
        // Reset is synchronous, so the write strobe must be cut combinationally to abort the store.
        mem_write_enable = write_q & ~addr_oor & ~reset;
        state_d          = RESP;
      end
      RESP: begin
        addr_error = addr_oor;
        if (owner_q == OWN_CPU) begin
          cpu_ack   = 1'b1;
          cpu_rdata = rdata_q;
        end else begin
          io_ack   = 1'b1;
          io_rdata = rdata_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed sequences for the multi-cycle corners
// followed by a table of single-requester transactions against a behavioural memory.
module tb_dmem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_write = 1'b0;
  logic [DW-1:0] cpu_address = '0, cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          io_req = 1'b0, io_write = 1'b0;
  logic [DW-1:0] io_address = '0, io_wdata = '0;
  logic          io_ack;
  logic [DW-1:0] io_rdata;
  logic          mem_write_enable;
  logic [DW-1:0] mem_address, mem_input_data, mem_output_data;
  logic          addr_error, busy;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_req          (cpu_req),
    .cpu_write        (cpu_write),
    .cpu_address      (cpu_address),
    .cpu_wdata        (cpu_wdata),
    .cpu_ack          (cpu_ack),
    .cpu_rdata        (cpu_rdata),
    .io_req           (io_req),
    .io_write         (io_write),
    .io_address       (io_address),
    .io_wdata         (io_wdata),
    .io_ack           (io_ack),
    .io_rdata         (io_rdata),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_input_data   (mem_input_data),
    .mem_output_data  (mem_output_data),
    .addr_error       (addr_error),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  // Behavioural memory: asynchronous read, write on posedge; initial contents tag each word with its index.
  logic [DW-1:0] mem [DEPTH];
  assign mem_output_data = mem[mem_address[AW-1:0]];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5_0000 | i;
    forever begin
      @(posedge clock);
      if (mem_write_enable) mem[mem_address[AW-1:0]] = mem_input_data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_txn(input bit port, input bit wr, input logic [DW-1:0] addr,
                         input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                         output bit err, output int lat, output int we_cnt);
    lat    = -1;
    we_cnt = 0;
    rd     = '0;
    err    = 1'b0;
    if (port == 1'b0) begin
      cpu_req = 1'b1; cpu_write = wr; cpu_address = addr; cpu_wdata = wd;
    end else begin
      io_req = 1'b1; io_write = wr; io_address = addr; io_wdata = wd;
    end
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mem_write_enable) we_cnt++;
      if ((port == 1'b0) ? cpu_ack : io_ack) begin
        lat = i;
        rd  = (port == 1'b0) ? cpu_rdata : io_rdata;
        err = addr_error;
        break;
      end
    end
    cpu_req = 1'b0;
    io_req  = 1'b0;
    tick();
  endtask

  typedef struct {
    bit            port;
    bit            wr;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
    bit            exp_err;
    int            exp_we;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [DW-1:0] rd;
    bit            err;
    int            lat, we_cnt, busy_cnt, first_ack, second_ack, n_ack;

    vecs[0] = '{1'b0, 1'b1, 32'd5,          32'hDEAD_BEEF, 32'h0,          1'b0, 1};
    vecs[1] = '{1'b0, 1'b0, 32'd5,          32'h0,         32'hDEAD_BEEF,  1'b0, 0};
    vecs[2] = '{1'b1, 1'b1, 32'd1023,       32'h1234_5678, 32'h0,          1'b0, 1};
    vecs[3] = '{1'b1, 1'b0, 32'd1023,       32'h0,         32'h1234_5678,  1'b0, 0};
    vecs[4] = '{1'b1, 1'b1, 32'd1024,       32'h0BAD_BAD0, 32'h0,          1'b1, 0};
    vecs[5] = '{1'b1, 1'b0, 32'd0,          32'h0,         32'hA5A5_0000,  1'b0, 0};
    vecs[6] = '{1'b0, 1'b0, 32'd1024,       32'h0,         32'h0,          1'b1, 0};
    vecs[7] = '{1'b0, 1'b1, 32'd0,          32'hCAFE_F00D, 32'h0,          1'b0, 1};
    vecs[8] = '{1'b1, 1'b0, 32'd0,          32'h0,         32'hCAFE_F00D,  1'b0, 0};
    vecs[9] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'h0,         32'h0,          1'b1, 0};

    // Reset state
    tick();
    tick();
    check("rst_busy",     busy,             0);
    check("rst_cpu_ack",  cpu_ack,          0);
    check("rst_io_ack",   io_ack,           0);
    check("rst_addr_err", addr_error,       0);
    check("rst_mem_we",   mem_write_enable, 0);
    check("rst_mem_addr", mem_address,      0);
    check("rst_cpu_rd",   cpu_rdata,        0);
    reset = 1'b0;
    tick();

    // Simultaneous loads: first tie goes to the CPU; the CPU then re-requests against the pending IO.
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 32'd5;
    io_req  = 1'b1; io_write  = 1'b0; io_address  = 32'd1023;
    tick(); tick();
    check("tie1_cpu_ack", cpu_ack, 1);
    check("tie1_io_ack",  io_ack,  0);
    check("tie1_rdata",   cpu_rdata, 32'hA5A5_0005);
    tick(); tick(); tick();
    check("tie2_cpu_ack", cpu_ack, !RR);
    check("tie2_io_ack",  io_ack,  RR);
    check("tie2_rdata",   RR ? io_rdata : cpu_rdata, RR ? 32'hA5A5_03FF : 32'hA5A5_0005);
    if (RR) io_req = 1'b0;
    else    cpu_req = 1'b0;
    tick(); tick(); tick();
    check("tie3_cpu_ack", cpu_ack, RR);
    check("tie3_io_ack",  io_ack,  !RR);
    check("tie3_rdata",   RR ? cpu_rdata : io_rdata, RR ? 32'hA5A5_0005 : 32'hA5A5_03FF);
    cpu_req = 1'b0;
    io_req  = 1'b0;
    tick();

    // Reset asserted during ISSUE of a store aborts it
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_address = 32'd7; cpu_wdata = 32'h7777_7777;
    tick();
    check("rsti_pre_we",   mem_write_enable, 1);
    check("rsti_pre_addr", mem_address, 7);
    reset   = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("rsti_we_cut", mem_write_enable, 0);
    tick();
    check("rsti_idle_busy", busy, 0);
    check("rsti_no_ack0",   cpu_ack, 0);
    reset = 1'b0;
    tick(); tick();
    check("rsti_no_ack1",   cpu_ack, 0);
    check("rsti_mem7",      mem[7], 32'hA5A5_0007);
    run_txn(1'b0, 1'b0, 32'd7, 32'h0, rd, err, lat, we_cnt);
    check("rsti_load7",     rd, 32'hA5A5_0007);

    // Command changes during ISSUE are ignored; busy spans exactly ISSUE and RESP
    busy_cnt = 0;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 32'd5;
    tick(); busy_cnt += int'(busy);
    cpu_address = 32'd9; cpu_write = 1'b1; cpu_wdata = 32'h9999_9999;
    #1;
    check("hold_mem_addr", mem_address, 5);
    check("hold_mem_we",   mem_write_enable, 0);
    tick(); busy_cnt += int'(busy);
    check("hold_ack",      cpu_ack, 1);
    check("hold_rdata",    cpu_rdata, 32'hA5A5_0005);
    check("hold_resp_mem", mem_address, 0);
    cpu_req = 1'b0;
    tick(); busy_cnt += int'(busy);
    tick(); busy_cnt += int'(busy);
    check("hold_busy_cnt", busy_cnt, 2);
    check("hold_mem9",     mem[9], 32'hA5A5_0009);

    // Request held across ack is a fresh transaction
    first_ack = -1; second_ack = -1; n_ack = 0;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 32'd5;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (cpu_ack) begin
        if (n_ack == 0) first_ack = i;
        else            second_ack = i;
        n_ack++;
        if (n_ack == 2) begin
          cpu_req = 1'b0;
          break;
        end
      end
    end
    cpu_req = 1'b0;
    tick();
    check("rep_n_ack", n_ack, 2);
    check("rep_first", first_ack, 2);
    check("rep_gap",   second_ack - first_ack, 3);

    // Single-requester transaction table
    for (int v = 0; v < 10; v++) begin
      run_txn(vecs[v].port, vecs[v].wr, vecs[v].addr, vecs[v].wdata, rd, err, lat, we_cnt);
      check($sformatf("vec%0d_rdata", v), rd,     vecs[v].exp_rd);
      check($sformatf("vec%0d_err",   v), err,    vecs[v].exp_err);
      check($sformatf("vec%0d_lat",   v), lat,    2);
      check($sformatf("vec%0d_we",    v), we_cnt, vecs[v].exp_we);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
